// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, ALU/fault codes and sequencer state encoding
package control_unit_pkg;

  localparam logic [4:0] OP_LD      = 5'b00000;
  localparam logic [4:0] OP_LDI     = 5'b00001;
  localparam logic [4:0] OP_ST      = 5'b00010;
  localparam logic [4:0] OP_ALUR_LO = 5'b00011;
  localparam logic [4:0] OP_ALUR_HI = 5'b01011;
  localparam logic [4:0] OP_ALUI_LO = 5'b01100;
  localparam logic [4:0] OP_ALUI_HI = 5'b01110;
  localparam logic [4:0] OP_BR      = 5'b10010;
  localparam logic [4:0] OP_JR      = 5'b10011;
  localparam logic [4:0] OP_NOP     = 5'b11010;
  localparam logic [4:0] OP_HALT    = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_MEM     = 2'b10;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALUR, C_ALUI, C_BR, C_JR, C_NOP, C_HALT, C_ILL
  } op_class_t;

  // Groups opcodes that share one execute sequence; anything unlisted is illegal.
  function automatic op_class_t decode_class(input logic [4:0] op);
    op_class_t c;
    c = C_ILL;
    if (op == OP_LD)                                 c = C_LD;
    else if (op == OP_LDI)                           c = C_LDI;
    else if (op == OP_ST)                            c = C_ST;
    else if (op >= OP_ALUR_LO && op <= OP_ALUR_HI)   c = C_ALUR;
    else if (op >= OP_ALUI_LO && op <= OP_ALUI_HI)   c = C_ALUI;
    else if (op == OP_BR)                            c = C_BR;
    else if (op == OP_JR)                            c = C_JR;
    else if (op == OP_NOP)                           c = C_NOP;
    else if (op == OP_HALT)                          c = C_HALT;
    return c;
  endfunction

endpackage

// File: rtl/control_unit_mem_wait_timer.sv
// rtl/control_unit_mem_wait_timer.sv - stall counter that flags a memory timeout
module control_unit_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  input  logic done,
  output logic timeout
);

  logic [7:0] cnt_q;

  // Count consecutive stalled cycles; leaving the wait or completing rewinds to zero.
  always_ff @(posedge clk) begin
    if (!clear) begin
      cnt_q <= '0;
    end else if (!en || done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires on the stalled cycle whose increment would make the count reach MEM_TIMEOUT.
  assign timeout = en && !done && (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore fetch/decode/execute sequencer for the DataPath
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             mem_done,
  input  logic             stop,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             Cout,
  output logic             BAout,
  output logic             Rout,
  output logic             MARin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             PCin,
  output logic             Rin,
  output logic             CONin,
  output logic             incPC,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic [4:0]       Operator,
  output logic             run,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state_q, state_d;
  logic [1:0] fault_q, fault_d;
  logic       count_en;
  logic       is_wait;
  logic       timeout;
  logic [4:0] opcode;
  op_class_t  cls;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign cls       = decode_class(opcode);
  assign unused_ir = ^ir[26:0];

  assign is_wait = (state_q == S_F2) ||
                   (state_q == S_E3 && cls == C_LD) ||
                   (state_q == S_E4 && cls == C_ST);

  control_unit_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .clear   (clear),
    .en      (is_wait),
    .done    (mem_done),
    .timeout (timeout)
  );

  // State, sticky fault and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q   <= S_F0;
      fault_q   <= FAULT_NONE;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (count_en) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Next state: walk the class sequence; a retiring exit honours stop, a stall timeout halts.
  always_comb begin
    logic retire;
    state_d  = state_q;
    fault_d  = fault_q;
    count_en = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: if (mem_done) state_d = S_F3;
      S_F3: state_d = S_E0;
      S_E0: begin
        case (cls)
          C_JR, C_NOP: retire = 1'b1;
          C_HALT: begin
            state_d  = S_HALT;
            count_en = 1'b1;
          end
          C_ILL: begin
            state_d = S_HALT;
            fault_d = FAULT_ILLEGAL;
          end
          default: state_d = S_E1;
        endcase
      end
      S_E1: state_d = S_E2;
      S_E2: begin
        if (cls == C_LD || cls == C_ST || cls == C_BR) state_d = S_E3;
        else retire = 1'b1;
      end
      S_E3: begin
        if (cls == C_BR) retire = 1'b1;
        else if (cls == C_ST || mem_done) state_d = S_E4;
      end
      S_E4: begin
        if (cls == C_LD || mem_done) retire = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
    if (retire) begin
      count_en = 1'b1;
      state_d  = stop ? S_HALT : S_F0;
    end
    if (timeout) begin
      state_d = S_HALT;
      fault_d = FAULT_MEM;
    end
  end

  // Output decode from registered state and opcode class; everything is quiet while clear is low.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; PCin = 1'b0;
    Rin = 1'b0; CONin = 1'b0; incPC = 1'b0; Read = 1'b0; Write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Operator = 5'b00000;
    if (clear) begin
      case (state_q)
        S_F0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1; end
        S_F1: begin Zlowout = 1'b1; PCin = 1'b1; end
        S_F2: begin Read = 1'b1; MDRin = 1'b1; end
        S_F3: begin MDRout = 1'b1; IRin = 1'b1; end
        S_E0: begin
          case (cls)
            C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            C_ALUR, C_ALUI:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
        S_E1: begin
          case (cls)
            C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; Operator = ALU_ADD; end
            C_ALUR:            begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; Operator = opcode; end
            C_ALUI:            begin Cout = 1'b1; Zin = 1'b1; Operator = opcode; end
            C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
            default: ;
          endcase
        end
        S_E2: begin
          case (cls)
            C_LD, C_ST:             begin Zlowout = 1'b1; MARin = 1'b1; end
            C_LDI, C_ALUR, C_ALUI:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_BR:                   begin Cout = 1'b1; Zin = 1'b1; Operator = ALU_ADD; end
            default: ;
          endcase
        end
        S_E3: begin
          case (cls)
            C_LD: begin Read = 1'b1; MDRin = 1'b1; end
            C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_BR: begin Zlowout = 1'b1; PCin = con_ff; end
            default: ;
          endcase
        end
        S_E4: begin
          case (cls)
            C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_ST: begin Write = 1'b1; MDRin = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign run   = (state_q != S_HALT);
  assign fault = fault_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk;
  logic        clear;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_done;
  logic        stop;

  logic PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, MDRin, IRin, Yin, Zin, PCin;
  logic Rin, CONin, incPC, Read, Write, Gra, Grb, Grc;
  logic [4:0]  Operator;
  logic        run;
  logic [1:0]  fault;
  logic [15:0] instr_cnt;

  logic d2_PCout, d2_Zlowout, d2_MDRout, d2_Cout, d2_BAout, d2_Rout, d2_MARin, d2_MDRin;
  logic d2_IRin, d2_Yin, d2_Zin, d2_PCin, d2_Rin, d2_CONin, d2_incPC, d2_Read, d2_Write;
  logic d2_Gra, d2_Grb, d2_Grc;
  logic [4:0]  d2_Operator;
  logic        d2_run;
  logic [1:0]  d2_fault;
  logic [15:0] d2_instr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [19:0] K_PCOUT   = 20'd1 << 19;
  localparam logic [19:0] K_ZLOWOUT = 20'd1 << 18;
  localparam logic [19:0] K_MDROUT  = 20'd1 << 17;
  localparam logic [19:0] K_COUT    = 20'd1 << 16;
  localparam logic [19:0] K_BAOUT   = 20'd1 << 15;
  localparam logic [19:0] K_ROUT    = 20'd1 << 14;
  localparam logic [19:0] K_MARIN   = 20'd1 << 13;
  localparam logic [19:0] K_MDRIN   = 20'd1 << 12;
  localparam logic [19:0] K_IRIN    = 20'd1 << 11;
  localparam logic [19:0] K_YIN     = 20'd1 << 10;
  localparam logic [19:0] K_ZIN     = 20'd1 << 9;
  localparam logic [19:0] K_PCIN    = 20'd1 << 8;
  localparam logic [19:0] K_RIN     = 20'd1 << 7;
  localparam logic [19:0] K_CONIN   = 20'd1 << 6;
  localparam logic [19:0] K_INCPC   = 20'd1 << 5;
  localparam logic [19:0] K_READ    = 20'd1 << 4;
  localparam logic [19:0] K_WRITE   = 20'd1 << 3;
  localparam logic [19:0] K_GRA     = 20'd1 << 2;
  localparam logic [19:0] K_GRB     = 20'd1 << 1;
  localparam logic [19:0] K_GRC     = 20'd1 << 0;
  localparam logic [19:0] K_NONE    = 20'd0;

  wire [19:0] strobes = {PCout, Zlowout, MDRout, Cout, BAout, Rout, MARin, MDRin, IRin, Yin,
                         Zin, PCin, Rin, CONin, incPC, Read, Write, Gra, Grb, Grc};
  wire [19:0] d2_strobes = {d2_PCout, d2_Zlowout, d2_MDRout, d2_Cout, d2_BAout, d2_Rout,
                            d2_MARin, d2_MDRin, d2_IRin, d2_Yin, d2_Zin, d2_PCin, d2_Rin,
                            d2_CONin, d2_incPC, d2_Read, d2_Write, d2_Gra, d2_Grb, d2_Grc};

  control_unit #(.MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
    .clk(clk), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_done(mem_done), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
    .Rout(Rout), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .PCin(PCin), .Rin(Rin), .CONin(CONin), .incPC(incPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Operator(Operator), .run(run), .fault(fault),
    .instr_cnt(instr_cnt)
  );

  control_unit #(.MEM_TIMEOUT(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_done(mem_done), .stop(stop),
    .PCout(d2_PCout), .Zlowout(d2_Zlowout), .MDRout(d2_MDRout), .Cout(d2_Cout),
    .BAout(d2_BAout), .Rout(d2_Rout), .MARin(d2_MARin), .MDRin(d2_MDRin), .IRin(d2_IRin),
    .Yin(d2_Yin), .Zin(d2_Zin), .PCin(d2_PCin), .Rin(d2_Rin), .CONin(d2_CONin),
    .incPC(d2_incPC), .Read(d2_Read), .Write(d2_Write), .Gra(d2_Gra), .Grb(d2_Grb),
    .Grc(d2_Grc), .Operator(d2_Operator), .run(d2_run), .fault(d2_fault),
    .instr_cnt(d2_instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st_chk(input string tag, input logic [19:0] s, input logic [4:0] op);
    chk({tag, " strobes"}, 32'(strobes), 32'(s));
    chk({tag, " op"}, 32'(Operator), 32'(op));
    tick();
  endtask

  task automatic fetch(input string tag);
    st_chk({tag, " F0"}, K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 5'd0);
    st_chk({tag, " F1"}, K_ZLOWOUT | K_PCIN, 5'd0);
    st_chk({tag, " F2"}, K_READ | K_MDRIN, 5'd0);
    st_chk({tag, " F3"}, K_MDROUT | K_IRIN, 5'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " strobes"}, 32'(strobes), 32'(K_NONE));
    chk({tag, " op"}, 32'(Operator), 32'd0);
    chk({tag, " run"}, 32'(run), 32'd1);
    chk({tag, " fault"}, 32'(fault), 32'd0);
    chk({tag, " cnt"}, 32'(instr_cnt), 32'd0);
  endtask

  initial begin
    clear = 1'b0; ir = 32'd0; con_ff = 1'b0; mem_done = 1'b1; stop = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    chk("reset d2 fault", 32'(d2_fault), 32'd0);
    clear = 1'b1;
    #1;

    // ld R1,85(R0) with memory answering immediately: 9 cycles F0..E4
    ir = {5'b00000, 4'd1, 4'd0, 19'd85};
    fetch("ld");
    st_chk("ld E0", K_GRB | K_BAOUT | K_YIN, 5'd0);
    st_chk("ld E1", K_COUT | K_ZIN, 5'b00011);
    st_chk("ld E2", K_ZLOWOUT | K_MARIN, 5'd0);
    st_chk("ld E3", K_READ | K_MDRIN, 5'd0);
    st_chk("ld E4", K_MDROUT | K_GRA | K_RIN, 5'd0);
    chk("ld cnt", 32'(instr_cnt), 32'd1);
    chk("ld back F0", 32'(strobes), 32'(K_PCOUT | K_MARIN | K_INCPC | K_ZIN));

    // add R3,R1,R2: 7 cycles
    ir = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
    fetch("add");
    st_chk("add E0", K_GRB | K_ROUT | K_YIN, 5'd0);
    st_chk("add E1", K_GRC | K_ROUT | K_ZIN, 5'b00011);
    st_chk("add E2", K_ZLOWOUT | K_GRA | K_RIN, 5'd0);
    chk("add cnt", 32'(instr_cnt), 32'd2);

    // br not taken then taken
    ir = {5'b10010, 27'd0};
    con_ff = 1'b0;
    fetch("br0");
    st_chk("br0 E0", K_GRA | K_ROUT | K_CONIN, 5'd0);
    st_chk("br0 E1", K_PCOUT | K_YIN, 5'd0);
    st_chk("br0 E2", K_COUT | K_ZIN, 5'b00011);
    st_chk("br0 E3", K_ZLOWOUT, 5'd0);
    con_ff = 1'b1;
    fetch("br1");
    st_chk("br1 E0", K_GRA | K_ROUT | K_CONIN, 5'd0);
    st_chk("br1 E1", K_PCOUT | K_YIN, 5'd0);
    st_chk("br1 E2", K_COUT | K_ZIN, 5'b00011);
    st_chk("br1 E3", K_ZLOWOUT | K_PCIN, 5'd0);
    chk("br cnt", 32'(instr_cnt), 32'd4);
    con_ff = 1'b0;

    // andi, jr, nop
    ir = {5'b01101, 27'd7};
    fetch("andi");
    st_chk("andi E0", K_GRB | K_ROUT | K_YIN, 5'd0);
    st_chk("andi E1", K_COUT | K_ZIN, 5'b01101);
    st_chk("andi E2", K_ZLOWOUT | K_GRA | K_RIN, 5'd0);
    ir = {5'b10011, 27'd0};
    fetch("jr");
    st_chk("jr E0", K_GRA | K_ROUT | K_PCIN, 5'd0);
    ir = {5'b11010, 27'd0};
    fetch("nop");
    st_chk("nop E0", K_NONE, 5'd0);
    chk("nop cnt", 32'(instr_cnt), 32'd7);

    // st with a 3-cycle memory delay; the MEM_TIMEOUT=2 copy times out instead
    ir = {5'b00010, 4'd2, 4'd0, 19'd16};
    fetch("st");
    st_chk("st E0", K_GRB | K_BAOUT | K_YIN, 5'd0);
    st_chk("st E1", K_COUT | K_ZIN, 5'b00011);
    st_chk("st E2", K_ZLOWOUT | K_MARIN, 5'd0);
    mem_done = 1'b0;
    st_chk("st E3", K_GRA | K_ROUT | K_MDRIN, 5'd0);
    st_chk("st E4w1", K_WRITE | K_MDRIN, 5'd0);
    st_chk("st E4w2", K_WRITE | K_MDRIN, 5'd0);
    chk("d2 timeout fault", 32'(d2_fault), 32'd2);
    chk("d2 timeout run", 32'(d2_run), 32'd0);
    chk("d2 halt strobes", 32'(d2_strobes), 32'(K_NONE));
    chk("d2 halt op", 32'(d2_Operator), 32'd0);
    chk("d2 cnt", 32'(d2_instr_cnt), 32'd7);
    st_chk("st E4w3", K_WRITE | K_MDRIN, 5'd0);
    mem_done = 1'b1;
    st_chk("st E4done", K_WRITE | K_MDRIN, 5'd0);
    chk("st cnt", 32'(instr_cnt), 32'd8);
    chk("st run", 32'(run), 32'd1);
    chk("st fault", 32'(fault), 32'd0);

    // illegal opcode halts without counting
    ir = {5'b11111, 27'd0};
    fetch("ill");
    st_chk("ill E0", K_NONE, 5'd0);
    chk("ill fault", 32'(fault), 32'd1);
    chk("ill run", 32'(run), 32'd0);
    chk("ill cnt", 32'(instr_cnt), 32'd8);
    tick();
    tick();
    chk("ill held strobes", 32'(strobes), 32'(K_NONE));
    chk("ill held run", 32'(run), 32'd0);

    // clear during HALT
    clear = 1'b0;
    tick();
    chk_reset("clr halt");
    chk("clr halt d2 fault", 32'(d2_fault), 32'd0);
    clear = 1'b1;
    #1;

    // stop raised mid-ldi: sequence completes, then HALT
    ir = {5'b00001, 4'd4, 4'd0, 19'd9};
    fetch("ldi");
    st_chk("ldi E0", K_GRB | K_BAOUT | K_YIN, 5'd0);
    stop = 1'b1;
    st_chk("ldi E1", K_COUT | K_ZIN, 5'b00011);
    st_chk("ldi E2", K_ZLOWOUT | K_GRA | K_RIN, 5'd0);
    chk("stop run", 32'(run), 32'd0);
    chk("stop cnt", 32'(instr_cnt), 32'd1);
    chk("stop fault", 32'(fault), 32'd0);
    chk("stop strobes", 32'(strobes), 32'(K_NONE));
    stop = 1'b0;
    tick();
    chk("stop held run", 32'(run), 32'd0);

    // clear during an F2 memory stall
    clear = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    ir = {5'b00011, 27'd0};
    mem_done = 1'b0;
    st_chk("stall F0", K_PCOUT | K_MARIN | K_INCPC | K_ZIN, 5'd0);
    st_chk("stall F1", K_ZLOWOUT | K_PCIN, 5'd0);
    st_chk("stall F2a", K_READ | K_MDRIN, 5'd0);
    chk("stall F2b strobes", 32'(strobes), 32'(K_READ | K_MDRIN));
    clear = 1'b0;
    tick();
    chk_reset("clr wait");
    chk("clr wait d2 run", 32'(d2_run), 32'd1);
    clear = 1'b1;
    #1;

    // halt instruction retires and counts
    ir = {5'b11011, 27'd0};
    mem_done = 1'b1;
    fetch("halt");
    st_chk("halt E0", K_NONE, 5'd0);
    chk("halt run", 32'(run), 32'd0);
    chk("halt cnt", 32'(instr_cnt), 32'd1);
    chk("halt fault", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
